// File: rtl/slot_select_decoder.sv
// Apple II slot select decoder: snoops the synchronized bus each phi0 cycle and
// drives ioselect_n/devselect_n/iostrobe_n plus C8 expansion-ROM ownership.
// Optional IIe CXROM/SLOTC3ROM soft switches: define APPLE_IIE_CXROM_EN.
module slot_select_decoder #(
  parameter logic [7:0] SLOT_MASK    = 8'hFE,
  parameter bit         CFFF_RELEASE = 1'b1
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic [15:0] addr,
  input  logic        rw_n,
  input  logic        phi0,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_slot,
  input  logic [7:0]  cfg_card_id,
  output logic [2:0]  slot,
  output logic [7:0]  card_id,
  output logic        ioselect_n,
  output logic        devselect_n,
  output logic        iostrobe_n,
  output logic [2:0]  c8_owner
);

  typedef enum logic [1:0] {SEL_NONE, SEL_DEV, SEL_IO, SEL_STB} sel_e;

  logic       r_phi0_d;
  logic [2:0] r_slot;
  logic [7:0] r_card_id;
  logic       r_ioselect_n;
  logic       r_devselect_n;
  logic       r_iostrobe_n;
  logic [2:0] r_c8_owner;
  logic       r_release_pend;
  logic [7:0] r_card_table [0:7];

  logic       w_decode;
  logic       w_hit;
  sel_e       w_kind;
  logic [2:0] w_slot;
  logic [7:0] w_card;
  logic       w_enabled;
  logic       w_rom_vis;
  logic       w_c3_block;
  logic       w_release;
  logic       w_assert;
  logic       w_own_set;
  logic       w_own_clr;

`ifdef APPLE_IIE_CXROM_EN
  logic r_intcxrom;
  logic r_slotc3rom;
`else
  logic w_unused;
  assign w_unused = rw_n;
`endif

  assign w_decode = phi0 & ~r_phi0_d;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_hit     = 1'b0;
    w_kind    = SEL_NONE;
    w_slot    = r_slot;
    w_release = 1'b0;
    if (addr[15:7] == 9'h181) begin
      w_hit  = 1'b1;
      w_kind = SEL_DEV;
      w_slot = addr[6:4];
    end else if (addr[15:11] == 5'b11000 && addr[10:8] != 3'd0) begin
      w_hit  = 1'b1;
      w_kind = SEL_IO;
      w_slot = addr[10:8];
    end else if (addr[15:11] == 5'b11001) begin
      w_release = CFFF_RELEASE && (addr == 16'hCFFF);
      if (r_c8_owner != 3'd0) begin
        w_hit  = 1'b1;
        w_kind = SEL_STB;
        w_slot = r_c8_owner;
      end
    end

    w_card    = r_card_table[w_slot];
    w_enabled = SLOT_MASK[w_slot] && (w_slot != 3'd0) && (w_card != 8'h00);

`ifdef APPLE_IIE_CXROM_EN
    w_rom_vis  = ~r_intcxrom;
    w_c3_block = (w_kind == SEL_IO) && (w_slot == 3'd3) && ~r_slotc3rom;
`else
    w_rom_vis  = 1'b1;
    w_c3_block = 1'b0;
`endif

    unique case (w_kind)
      SEL_DEV: w_assert = w_enabled;
      SEL_IO:  w_assert = w_enabled && w_rom_vis && ~w_c3_block;
      SEL_STB: w_assert = w_enabled && w_rom_vis;
      default: w_assert = 1'b0;
    endcase

    // A disabled $C3 ROM drops ownership even for an empty slot, unless CXROM hides all slots.
    w_own_clr = w_rom_vis && w_c3_block;
    w_own_set = (w_kind == SEL_IO) && w_enabled && w_rom_vis && ~w_c3_block;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      // Seeded high so a reset released mid-phi0 cannot fake a rising edge.
      r_phi0_d       <= 1'b1;
      r_slot         <= 3'd0;
      r_card_id      <= 8'h00;
      r_ioselect_n   <= 1'b1;
      r_devselect_n  <= 1'b1;
      r_iostrobe_n   <= 1'b1;
      r_c8_owner     <= 3'd0;
      r_release_pend <= 1'b0;
`ifdef APPLE_IIE_CXROM_EN
      r_intcxrom     <= 1'b0;
      r_slotc3rom    <= 1'b0;
`endif
    end else begin
      r_phi0_d <= phi0;
      if (w_decode) begin
        if (w_hit) begin
          r_slot    <= w_slot;
          r_card_id <= w_card;
        end
        r_devselect_n  <= ~(w_assert && w_kind == SEL_DEV);
        r_ioselect_n   <= ~(w_assert && w_kind == SEL_IO);
        r_iostrobe_n   <= ~(w_assert && w_kind == SEL_STB);
        r_release_pend <= w_release;
        if (w_own_set)      r_c8_owner <= w_slot;
        else if (w_own_clr) r_c8_owner <= 3'd0;
`ifdef APPLE_IIE_CXROM_EN
        if (!rw_n) begin
          unique case (addr)
            16'hC006: r_intcxrom  <= 1'b0;
            16'hC007: r_intcxrom  <= 1'b1;
            16'hC00A: r_slotc3rom <= 1'b0;
            16'hC00B: r_slotc3rom <= 1'b1;
            default: ;
          endcase
        end
`endif
      end else if (!phi0) begin
        r_devselect_n  <= 1'b1;
        r_ioselect_n   <= 1'b1;
        r_iostrobe_n   <= 1'b1;
        r_release_pend <= 1'b0;
        if (r_release_pend) r_c8_owner <= 3'd0;
      end
    end
  end

  // NOTE: the card table is only eight bytes and must read as empty after
  // reset, so it is reset along with the control state.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      for (int i = 0; i < 8; i++) r_card_table[i] <= 8'h00;
    end else if (cfg_we && cfg_slot != 3'd0) begin
      r_card_table[cfg_slot] <= cfg_card_id;
    end
  end

  assign slot        = r_slot;
  assign card_id     = r_card_id;
  assign ioselect_n  = r_ioselect_n;
  assign devselect_n = r_devselect_n;
  assign iostrobe_n  = r_iostrobe_n;
  assign c8_owner    = r_c8_owner;

endmodule

// File: tb/tb_slot_select_decoder.sv
// Directed bench for slot_select_decoder; define APPLE_IIE_CXROM_EN to also
// cover the IIe soft switches.
module tb_slot_select_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw_n = 1'b1;
  logic        phi0 = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_slot = 3'd0;
  logic [7:0]  cfg_card_id = 8'h00;
  logic [2:0]  slot;
  logic [7:0]  card_id;
  logic        ioselect_n;
  logic        devselect_n;
  logic        iostrobe_n;
  logic [2:0]  c8_owner;

  int total = 0;
  int bad = 0;

  slot_select_decoder dut (
    .clk_logic      (clk),
    .system_reset_n (rst_n),
    .addr           (addr),
    .rw_n           (rw_n),
    .phi0           (phi0),
    .cfg_we         (cfg_we),
    .cfg_slot       (cfg_slot),
    .cfg_card_id    (cfg_card_id),
    .slot           (slot),
    .card_id        (card_id),
    .ioselect_n     (ioselect_n),
    .devselect_n    (devselect_n),
    .iostrobe_n     (iostrobe_n),
    .c8_owner       (c8_owner)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] s, input logic [7:0] id);
    cfg_we = 1'b1; cfg_slot = s; cfg_card_id = id;
    clk1();
    cfg_we = 1'b0;
  endtask

  // Full bus cycle: phi0 high for two clocks, then low for two clocks.
  task automatic bus_cycle(input logic [15:0] a, input logic rw);
    addr = a; rw_n = rw; phi0 = 1'b1;
    clk1(); clk1();
    phi0 = 1'b0;
    clk1(); clk1();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk1(); clk1();
    rst_n = 1'b1;
    clk1();
    total++; if (slot !== 3'd0) begin bad++; $display("FAIL reset_slot: got %0d want 0", slot); end
    total++; if (card_id !== 8'h00) begin bad++; $display("FAIL reset_card_id: got %h want 00", card_id); end
    total++; if ({ioselect_n, devselect_n, iostrobe_n} !== 3'b111) begin bad++; $display("FAIL reset_strobes: got %b want 111", {ioselect_n, devselect_n, iostrobe_n}); end
    total++; if (c8_owner !== 3'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", c8_owner); end
  endtask

  task automatic test_devselect();
    cfg_write(3'd4, 8'h21);
    addr = 16'hC0C3; rw_n = 1'b1; phi0 = 1'b1;
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL dev_pre_edge: got %b want 1", devselect_n); end
    clk1();
    total++; if (devselect_n !== 1'b0) begin bad++; $display("FAIL dev_low: got %b want 0", devselect_n); end
    total++; if (slot !== 3'd4) begin bad++; $display("FAIL dev_slot: got %0d want 4", slot); end
    total++; if (card_id !== 8'h21) begin bad++; $display("FAIL dev_card_id: got %h want 21", card_id); end
    total++; if ({ioselect_n, iostrobe_n} !== 2'b11) begin bad++; $display("FAIL dev_others: got %b want 11", {ioselect_n, iostrobe_n}); end
    clk1();
    total++; if (devselect_n !== 1'b0) begin bad++; $display("FAIL dev_hold: got %b want 0", devselect_n); end
    phi0 = 1'b0;
    #1;
    total++; if (devselect_n !== 1'b0) begin bad++; $display("FAIL dev_at_fall: got %b want 0", devselect_n); end
    clk1();
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL dev_release: got %b want 1", devselect_n); end
    clk1();
  endtask

  task automatic test_ownership();
    addr = 16'hC400; phi0 = 1'b1; clk1();
    total++; if (ioselect_n !== 1'b0) begin bad++; $display("FAIL own_iosel: got %b want 0", ioselect_n); end
    total++; if (c8_owner !== 3'd4) begin bad++; $display("FAIL own_set: got %0d want 4", c8_owner); end
    clk1(); phi0 = 1'b0; clk1(); clk1();
    total++; if (ioselect_n !== 1'b1) begin bad++; $display("FAIL own_iosel_rel: got %b want 1", ioselect_n); end

    addr = 16'hC800; phi0 = 1'b1; clk1();
    total++; if (iostrobe_n !== 1'b0) begin bad++; $display("FAIL c8_strobe: got %b want 0", iostrobe_n); end
    total++; if (slot !== 3'd4) begin bad++; $display("FAIL c8_slot: got %0d want 4", slot); end
    clk1(); phi0 = 1'b0; clk1(); clk1();

    addr = 16'hCFFF; phi0 = 1'b1; clk1();
    total++; if (iostrobe_n !== 1'b0) begin bad++; $display("FAIL cfff_strobe: got %b want 0", iostrobe_n); end
    total++; if (c8_owner !== 3'd4) begin bad++; $display("FAIL cfff_owner_held: got %0d want 4", c8_owner); end
    clk1(); phi0 = 1'b0; clk1();
    total++; if (c8_owner !== 3'd0) begin bad++; $display("FAIL cfff_release: got %0d want 0", c8_owner); end
    total++; if (iostrobe_n !== 1'b1) begin bad++; $display("FAIL cfff_strobe_rel: got %b want 1", iostrobe_n); end
    clk1();

    addr = 16'hC900; phi0 = 1'b1; clk1();
    total++; if (iostrobe_n !== 1'b1) begin bad++; $display("FAIL c9_no_owner: got %b want 1", iostrobe_n); end
    total++; if (slot !== 3'd4) begin bad++; $display("FAIL c9_slot_hold: got %0d want 4", slot); end
    clk1(); phi0 = 1'b0; clk1(); clk1();
  endtask

  task automatic test_suppression();
    addr = 16'hC0E0; phi0 = 1'b1; clk1();
    total++; if (slot !== 3'd6) begin bad++; $display("FAIL empty_slot: got %0d want 6", slot); end
    total++; if (card_id !== 8'h00) begin bad++; $display("FAIL empty_card_id: got %h want 00", card_id); end
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL empty_devsel: got %b want 1", devselect_n); end
    clk1(); phi0 = 1'b0; clk1(); clk1();

    // Slot 0 is masked and writes to it are dropped.
    cfg_write(3'd0, 8'h77);
    addr = 16'hC080; phi0 = 1'b1; clk1();
    total++; if (slot !== 3'd0) begin bad++; $display("FAIL slot0_slot: got %0d want 0", slot); end
    total++; if (card_id !== 8'h00) begin bad++; $display("FAIL slot0_card_id: got %h want 00", card_id); end
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL slot0_devsel: got %b want 1", devselect_n); end
    clk1(); phi0 = 1'b0; clk1(); clk1();

    // Empty slot ROM must not take ownership.
    addr = 16'hC600; phi0 = 1'b1; clk1();
    total++; if (ioselect_n !== 1'b1) begin bad++; $display("FAIL empty_iosel: got %b want 1", ioselect_n); end
    total++; if (c8_owner !== 3'd0) begin bad++; $display("FAIL empty_owner: got %0d want 0", c8_owner); end
    clk1(); phi0 = 1'b0; clk1(); clk1();

    // Outside any decoded range: slot/card_id hold.
    bus_cycle(16'h1234, 1'b1);
    total++; if (slot !== 3'd6) begin bad++; $display("FAIL outside_slot: got %0d want 6", slot); end
    total++; if ({ioselect_n, devselect_n, iostrobe_n} !== 3'b111) begin bad++; $display("FAIL outside_strobes: got %b want 111", {ioselect_n, devselect_n, iostrobe_n}); end
  endtask

  task automatic test_cfg_same_clk();
    addr = 16'hC0E0; phi0 = 1'b1;
    cfg_we = 1'b1; cfg_slot = 3'd6; cfg_card_id = 8'h55;
    clk1();
    cfg_we = 1'b0;
    total++; if (card_id !== 8'h00) begin bad++; $display("FAIL samecfg_card_id: got %h want 00", card_id); end
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL samecfg_devsel: got %b want 1", devselect_n); end
    clk1(); phi0 = 1'b0; clk1(); clk1();
    addr = 16'hC0E5; phi0 = 1'b1; clk1();
    total++; if (card_id !== 8'h55) begin bad++; $display("FAIL newcfg_card_id: got %h want 55", card_id); end
    total++; if (devselect_n !== 1'b0) begin bad++; $display("FAIL newcfg_devsel: got %b want 0", devselect_n); end
    clk1(); phi0 = 1'b0; clk1(); clk1();
  endtask

`ifdef APPLE_IIE_CXROM_EN
  task automatic test_cxrom();
    bus_cycle(16'hC007, 1'b0);
    addr = 16'hC400; rw_n = 1'b1; phi0 = 1'b1; clk1();
    total++; if (ioselect_n !== 1'b1) begin bad++; $display("FAIL cxrom_on_iosel: got %b want 1", ioselect_n); end
    clk1(); phi0 = 1'b0; clk1(); clk1();
    bus_cycle(16'hC006, 1'b0);
    addr = 16'hC400; rw_n = 1'b1; phi0 = 1'b1; clk1();
    total++; if (ioselect_n !== 1'b0) begin bad++; $display("FAIL cxrom_off_iosel: got %b want 0", ioselect_n); end
    clk1(); phi0 = 1'b0; clk1(); clk1();
  endtask
`endif

  task automatic test_reset_midcycle();
    addr = 16'hC0C3; rw_n = 1'b1; phi0 = 1'b1; clk1();
    total++; if (devselect_n !== 1'b0) begin bad++; $display("FAIL mid_pre_reset: got %b want 0", devselect_n); end
    rst_n = 1'b0;
    #1;
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL mid_async_clear: got %b want 1", devselect_n); end
    clk1();
    rst_n = 1'b1;
    // Table was cleared by reset; reload slot 4 while phi0 is still high.
    cfg_write(3'd4, 8'h21);
    clk1(); clk1();
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL mid_no_decode: got %b want 1", devselect_n); end
    phi0 = 1'b0; clk1(); clk1();
    phi0 = 1'b1; clk1();
    total++; if (devselect_n !== 1'b0) begin bad++; $display("FAIL mid_fresh_edge: got %b want 0", devselect_n); end
    clk1(); phi0 = 1'b0; clk1();
    total++; if (devselect_n !== 1'b1) begin bad++; $display("FAIL mid_final_rel: got %b want 1", devselect_n); end
  endtask

  initial begin
    test_reset();
    test_devselect();
    test_ownership();
    test_suppression();
    test_cfg_same_clk();
`ifdef APPLE_IIE_CXROM_EN
    test_cxrom();
`endif
    test_reset_midcycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
